lsu_controller: RTL and testbench

//  Sequences RV32I data-memory accesses requested by the decoded LOAD/STORE controls (mem_read, mem_write,

---
 rtl/rv32i_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_controller.sv | 199 +++++++++++++++++++
 tb/tb_lsu_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I load/store path:
//   - inst_size encodings (WORD/HALF/BYTE, plus the reserved code)
//   - err_code values reported alongside mem_err
//   - lsu_state_t, the load/store controller state enum
//   - is_misaligned(), the natural-alignment rule for a given access size
// ----------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_RW_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10,
    LSU_ERR  = 2'b11
  } lsu_state_t;

  // Bytes can sit anywhere, halves need an even address, and words (and the
  // reserved size, which behaves as a word) need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane handling for the load/store unit.
// Ports:
//   size       in  2   access size (rv32i_pkg SIZE_* encoding)
//   offset     in  2   byte offset within the word (addr[1:0])
//   is_signed  in  1   sign-extend (1) or zero-extend (0) sub-word loads
//   store_data in  32  raw store operand, LSBs significant for BYTE/HALF
//   read_word  in  32  word returned by the memory bus
//   strobe     out 4   byte enables for the addressed lanes
//   store_word out 32  store operand replicated across all lanes
//   load_word  out 32  addressed lane extracted and extended to 32 bits
// ----------------------------------------------------------------------------
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  strobe,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Store side: the operand is copied into every lane so the memory only has
  // to honour the strobes; the strobes pick the lanes that actually change.
  always_comb begin
    strobe     = 4'b1111;
    store_word = store_data;
    case (size)
      SIZE_BYTE: begin
        strobe     = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        strobe     = 4'b0011 << {offset[1], 1'b0};
        store_word = {2{store_data[15:0]}};
      end
      default: begin
        strobe     = 4'b1111;
        store_word = store_data;
      end
    endcase
  end

  // Load side: pick the addressed byte or half out of the returned word and
  // widen it, replicating the top bit only for signed loads.
  always_comb begin
    byte_lane = read_word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? read_word[31:16] : read_word[15:0];
    load_word = read_word;
    case (size)
      SIZE_BYTE: load_word = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_word = {{16{is_signed & half_lane[15]}}, half_lane};
      default:   load_word = read_word;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// ----------------------------------------------------------------------------
// lsu_controller
// Sequences one RV32I data-memory access at a time onto a req/ack bus with
// wait states, freezing the pipeline until the access completes or aborts.
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles allowed without bus_ack before abort (0 = none)
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   mem_read, mem_write    decoded load/store request, held while stall=1
//   inst_size, is_signed   access width and load extension mode
//   addr, wdata            byte address and store operand
//   stall                  freeze request to the upstream pipeline
//   load_valid, load_data  one-cycle completion pulse and registered result
//   mem_err, err_code      one-cycle abort pulse and its cause
//   bus_req/we/addr/wstrb/wdata   memory request, held until bus_ack
//   bus_ack, bus_rdata     memory completion and read word
// ----------------------------------------------------------------------------
module lsu_controller
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        mem_err,
  output logic [1:0]  err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t        state;
  lsu_state_t        next_state;

  logic [31:0]       addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       load_data_q;

  logic              req_any;
  logic [1:0]        req_code;
  logic              timeout_hit;

  logic [3:0]        lane_strobe;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_load;

  // The aligner works from the latched request so the bus stays stable even
  // if the pipeline inputs wobble; the load path uses the live read word.
  lsu_align u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .is_signed  (signed_q),
    .store_data (wdata_q),
    .read_word  (bus_rdata),
    .strobe     (lane_strobe),
    .store_word (lane_wdata),
    .load_word  (lane_load)
  );

  // Classify the request being presented in IDLE. Asking to read and write
  // at once is reported ahead of alignment since the access is meaningless.
  always_comb begin
    req_any  = mem_read | mem_write;
    req_code = ERR_NONE;
    if (mem_read && mem_write) begin
      req_code = ERR_RW_BOTH;
    end else if (is_misaligned(inst_size, addr[1:0])) begin
      req_code = ERR_MISALIGN;
    end
  end

  // The timeout fires on the last permitted REQ cycle, so bus_req is seen
  // for exactly TIMEOUT_CYCLES cycles before the abort.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  end

  // Next-state and output decode. stall rises combinationally in IDLE so the
  // pipeline freezes in the same cycle the request appears, and drops in
  // DONE/ERR so the instruction retires while its result is presented.
  // Bus fields are only driven while a request is outstanding.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    load_valid = 1'b0;
    mem_err    = 1'b0;
    err_code   = ERR_NONE;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'h0;
    bus_wstrb  = 4'b0000;
    bus_wdata  = 32'h0;
    case (state)
      LSU_IDLE: begin
        if (req_any) begin
          stall      = 1'b1;
          next_state = (req_code == ERR_NONE) ? LSU_REQ : LSU_ERR;
        end
      end
      LSU_REQ: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_we   = we_q;
        bus_addr = {addr_q[31:2], 2'b00};
        if (we_q) begin
          bus_wstrb = lane_strobe;
          bus_wdata = lane_wdata;
        end
        if (bus_ack) begin
          next_state = LSU_DONE;
        end else if (timeout_hit) begin
          next_state = LSU_ERR;
        end
      end
      LSU_DONE: begin
        load_valid = ~we_q;
        next_state = LSU_IDLE;
      end
      LSU_ERR: begin
        mem_err    = 1'b1;
        err_code   = err_q;
        next_state = LSU_IDLE;
      end
      default: begin
        next_state = LSU_IDLE;
      end
    endcase
  end

  // State register plus the latched request. The request is captured once in
  // IDLE and then held; an ack outside REQ never touches anything. The wait
  // counter saturates so an unbounded wait (TIMEOUT_CYCLES = 0) cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LSU_IDLE;
      addr_q      <= 32'h0;
      size_q      <= SIZE_WORD;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      err_q       <= ERR_NONE;
      cnt_q       <= '0;
      load_data_q <= 32'h0;
    end else begin
      state <= next_state;
      case (state)
        LSU_IDLE: begin
          if (req_any) begin
            addr_q   <= addr;
            size_q   <= inst_size;
            signed_q <= is_signed;
            we_q     <= mem_write;
            wdata_q  <= wdata;
            err_q    <= req_code;
            cnt_q    <= '0;
          end
        end
        LSU_REQ: begin
          if (bus_ack) begin
            if (!we_q) begin
              load_data_q <= lane_load;
            end
          end else if (timeout_hit) begin
            err_q <= ERR_TIMEOUT;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_controller.sv
// ----------------------------------------------------------------------------
// tb_lsu_controller
// Self-checking bench for lsu_controller with a short timeout so that the
// abort path is reachable. Expected bus fields, load results and error codes
// come from arithmetic models of the load/store rules kept in this file.
// ----------------------------------------------------------------------------
module tb_lsu_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  inst_size;
  logic        is_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        mem_err;
  logic [1:0]  err_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_load = 32'h0;

  lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .inst_size  (inst_size),
    .is_signed  (is_signed),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
    .mem_err    (mem_err),
    .err_code   (err_code),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  // Reference rules, stated in terms of byte offsets and multiplication.
  function automatic logic [1:0] model_err(input logic rd, input logic wr,
                                           input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (rd && wr) return 2'b11;
    if (sz == 2'b10) return 2'b00;
    if (sz == 2'b01) return (off % 2 != 0) ? 2'b01 : 2'b00;
    return (off != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [3:0] model_strobe(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'b10) return 4'((1 << off) & 15);
    if (sz == 2'b01) return 4'((3 << off) & 15);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b10) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_loadval(input logic [1:0] sz, input logic sgn,
                                                input logic [31:0] a, input logic [31:0] rdat);
    logic [31:0] v;
    v = rdat >> (8 * (a % 4));
    if (sz == 2'b10) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdat;
    end
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_ack   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({stall, bus_req, load_valid, mem_err} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL idle_ctrl: got %b expected %b", {stall, bus_req, load_valid, mem_err}, 4'b0000);
      end
      next_cycle();
    end
  endtask

  // One complete instruction: present it in IDLE, play the bus responder for
  // up to TO request cycles, then check the completion or abort cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int wait_cyc, input string tag);
    logic [1:0]  ecode;
    logic [3:0]  estrb;
    logic [31:0] ewdata;
    logic [31:0] eaddr;
    logic        acked;
    ecode  = model_err(rd, wr, sz, a);
    estrb  = wr ? model_strobe(sz, a) : 4'b0000;
    ewdata = model_store(sz, wd);
    eaddr  = a & 32'hFFFF_FFFC;

    mem_read  = rd;
    mem_write = wr;
    inst_size = sz;
    is_signed = sgn;
    addr      = a;
    wdata     = wd;
    bus_ack   = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, bus_req, load_valid, mem_err, err_code} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL %s issue_ctrl: got %b expected %b", tag,
               {stall, bus_req, load_valid, mem_err, err_code}, 6'b100000);
    end
    next_cycle();

    if (ecode != 2'b00) begin
      @(negedge clk);
      checks++;
      if ({stall, bus_req, load_valid, mem_err, err_code} !== {4'b0001, ecode}) begin
        errors++;
        $display("[TB] FAIL %s err_ctrl: got %b expected %b", tag,
                 {stall, bus_req, load_valid, mem_err, err_code}, {4'b0001, ecode});
      end
      checks++;
      if (load_data !== model_load) begin
        errors++;
        $display("[TB] FAIL %s err_load_data: got %h expected %h", tag, load_data, model_load);
      end
      next_cycle();
    end else begin
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        bus_ack   = (k == wait_cyc);
        bus_rdata = rdat;
        @(negedge clk);
        checks++;
        if ({stall, bus_req, load_valid, mem_err, err_code} !== 6'b110000) begin
          errors++;
          $display("[TB] FAIL %s req_ctrl[%0d]: got %b expected %b", tag, k,
                   {stall, bus_req, load_valid, mem_err, err_code}, 6'b110000);
        end
        checks++;
        if ({bus_we, bus_wstrb, bus_addr} !== {wr, estrb, eaddr}) begin
          errors++;
          $display("[TB] FAIL %s req_bus[%0d]: got we=%b strb=%b addr=%h expected we=%b strb=%b addr=%h",
                   tag, k, bus_we, bus_wstrb, bus_addr, wr, estrb, eaddr);
        end
        if (wr) begin
          checks++;
          if (bus_wdata !== ewdata) begin
            errors++;
            $display("[TB] FAIL %s req_wdata[%0d]: got %h expected %h", tag, k, bus_wdata, ewdata);
          end
        end
        acked = (k == wait_cyc);
        next_cycle();
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
      if (acked) begin
        if (rd) model_load = model_loadval(sz, sgn, a, rdat);
        checks++;
        if ({stall, bus_req, load_valid, mem_err, err_code} !== {2'b00, rd, 3'b000}) begin
          errors++;
          $display("[TB] FAIL %s done_ctrl: got %b expected %b", tag,
                   {stall, bus_req, load_valid, mem_err, err_code}, {2'b00, rd, 3'b000});
        end
      end else begin
        checks++;
        if ({stall, bus_req, load_valid, mem_err, err_code} !== 6'b000110) begin
          errors++;
          $display("[TB] FAIL %s timeout_ctrl: got %b expected %b", tag,
                   {stall, bus_req, load_valid, mem_err, err_code}, 6'b000110);
        end
      end
      checks++;
      if (load_data !== model_load) begin
        errors++;
        $display("[TB] FAIL %s load_data: got %h expected %h", tag, load_data, model_load);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    inst_size = 2'b00;
    is_signed = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if ({stall, bus_req, load_valid, mem_err, err_code, bus_we, bus_wstrb} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b",
               {stall, bus_req, load_valid, mem_err, err_code, bus_we, bus_wstrb}, 11'b0);
    end
    checks++;
    if ({load_data, bus_addr, bus_wdata} !== 96'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h expected zeros", load_data, bus_addr, bus_wdata);
    end
    next_cycle();
    reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_spec_vectors();
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, "lw_wait");
    checks++;
    if (load_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL lw_value: got %h expected %h", load_data, 32'hDEADBEEF);
    end
    do_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, "lb");
    checks++;
    if (load_data !== 32'hFFFFFF80) begin
      errors++;
      $display("[TB] FAIL lb_value: got %h expected %h", load_data, 32'hFFFFFF80);
    end
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, "lbu");
    checks++;
    if (load_data !== 32'h00000080) begin
      errors++;
      $display("[TB] FAIL lbu_value: got %h expected %h", load_data, 32'h00000080);
    end
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h206, 32'h0000ABCD, 32'h0, 0, "sh");
    checks++;
    if (load_data !== 32'h00000080) begin
      errors++;
      $display("[TB] FAIL sh_keeps_load: got %h expected %h", load_data, 32'h00000080);
    end
    idle_cycles(1);
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h0, 0, "lw_misaligned");
    idle_cycles(1);
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h12345678, 99, "timeout");
    idle_cycles(1);
  endtask

  task automatic test_rw_both();
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h55, 32'h0, 0, "rw_both");
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    mem_read  = 1'b1;
    mem_write = 1'b0;
    inst_size = 2'b00;
    is_signed = 1'b0;
    addr      = 32'h300;
    next_cycle();
    next_cycle();
    reset    = 1'b1;
    mem_read = 1'b0;
    next_cycle();
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    model_load = 32'h0;
    @(negedge clk);
    checks++;
    if ({stall, bus_req, load_valid, mem_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_ctrl: got %b expected %b", {stall, bus_req, load_valid, mem_err}, 4'b0000);
    end
    next_cycle();
    bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, bus_req, load_valid, mem_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got %b expected %b", {stall, bus_req, load_valid, mem_err}, 4'b0000);
    end
    checks++;
    if (load_data !== model_load) begin
      errors++;
      $display("[TB] FAIL reset_mid_load: got %h expected %h", load_data, model_load);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h501, 32'h000000A5, 32'h0, 0, "b2b_sb");
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h502, 32'h0, 32'h9ABC1234, 2, "b2b_lh");
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h504, 32'h0, 32'h0BADF00D, 0, "b2b_rsvd");
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r <= 5);
      wr = (r == 0) || (r >= 6);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b10) a[1:0] = 2'b00;
      end
      do_access(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, 5), "random");
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_rw_both();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
